// File: rtl/data_mem_responder_if.sv
// CPU data-memory port bundle: MEM-stage request, combinational read data and status.
interface data_mem_responder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             dm_we;
    logic [WIDTH-1:0] dm_addr;
    logic [WIDTH-1:0] dm_wdata;
    logic [WIDTH-1:0] dm_rdata;
    logic             busy;
    logic             mmio_valid;
    logic [WIDTH-1:0] mmio_data;
    logic             err_misaligned;
    logic             err_range;

    modport master (
        output dm_we, dm_addr, dm_wdata,
        input  dm_rdata, busy, mmio_valid, mmio_data, err_misaligned, err_range
    );

    modport slave (
        input  dm_we, dm_addr, dm_wdata,
        output dm_rdata, busy, mmio_valid, mmio_data, err_misaligned, err_range
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM with combinational read, post-reset clear engine,
// one MMIO debug word and sticky misaligned/out-of-range error flags.
module data_mem_responder #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH_WORDS = 1024,
    parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [WIDTH-1:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave dm
);
    localparam int unsigned     AW       = $clog2(DEPTH_WORDS);
    localparam logic [WIDTH:0]  RamBytes = (WIDTH + 1)'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0]   LastWord = AW'(DEPTH_WORDS - 1);

    typedef enum logic {StClear, StServe} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             busy_q, busy_d;
    logic             mmio_valid_q, mmio_valid_d;
    logic [WIDTH-1:0] mmio_data_q, mmio_data_d;
    logic [WIDTH-1:0] mmio_cnt_q, mmio_cnt_d;
    logic             err_mis_q, err_mis_d;
    logic             err_rng_q, err_rng_d;

    logic [WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [WIDTH-1:0] offset;
    logic [AW-1:0]    idx;
    logic             hit_mmio, hit_ram, misaligned, serve;
    logic             mem_we;
    logic [AW-1:0]    mem_widx;
    logic [WIDTH-1:0] mem_wdata;
    logic             unused_offset;

    // Offset wraps modulo 2^WIDTH, so addresses below BASE_ADDR land far out of range.
    assign offset        = dm.dm_addr - BASE_ADDR;
    assign idx           = offset[AW+1:2];
    assign hit_mmio      = (dm.dm_addr == MMIO_ADDR);
    assign hit_ram       = !hit_mmio && ({1'b0, offset} < RamBytes);
    assign misaligned    = (dm.dm_addr[1:0] != 2'b00);
    assign serve         = (state_q == StServe);
    assign unused_offset = ^offset[1:0];

    assign mem_we    = !serve || (dm.dm_we && hit_ram && !misaligned);
    assign mem_widx  = serve ? idx : clr_cnt_q;
    assign mem_wdata = serve ? dm.dm_wdata : '0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_comb begin
        dm.dm_rdata = '0;
        if (serve) begin
            if (hit_ram) begin
                dm.dm_rdata = mem_q[idx];
            end else if (hit_mmio) begin
                dm.dm_rdata = mmio_cnt_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        busy_d       = busy_q;
        mmio_valid_d = 1'b0;
        mmio_data_d  = mmio_data_q;
        mmio_cnt_d   = mmio_cnt_q;
        err_mis_d    = err_mis_q;
        err_rng_d    = err_rng_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LastWord) begin
                    state_d = StServe;
                    busy_d  = 1'b0;
                end
            end
            StServe: begin
                if (dm.dm_we) begin
                    if (misaligned) err_mis_d = 1'b1;
                    if (!hit_ram && !hit_mmio) err_rng_d = 1'b1;
                    if (hit_mmio && !misaligned) begin
                        mmio_data_d  = dm.dm_wdata;
                        mmio_valid_d = 1'b1;
                        mmio_cnt_d   = mmio_cnt_q + WIDTH'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            busy_q       <= 1'b1;
            mmio_valid_q <= 1'b0;
            mmio_data_q  <= '0;
            mmio_cnt_q   <= '0;
            err_mis_q    <= 1'b0;
            err_rng_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            busy_q       <= busy_d;
            mmio_valid_q <= mmio_valid_d;
            mmio_data_q  <= mmio_data_d;
            mmio_cnt_q   <= mmio_cnt_d;
            err_mis_q    <= err_mis_d;
            err_rng_q    <= err_rng_d;
        end
    end

    assign dm.busy           = busy_q;
    assign dm.mmio_valid     = mmio_valid_q;
    assign dm.mmio_data      = mmio_data_q;
    assign dm.err_misaligned = err_mis_q;
    assign dm.err_range      = err_rng_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a 16-word RAM: vector table for
// SERVE-state accesses plus hand-written clear and mid-clear reset sequences.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    data_mem_responder_if #(.WIDTH(32)) dm_if ();

    data_mem_responder #(
        .WIDTH      (32),
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (32'h0000_0000),
        .MMIO_ADDR  (MMIO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dm (dm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic        rng;
        logic        mv;
        logic [31:0] mdata;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Counts cycles until busy drops while hammering writes that must be ignored.
    task automatic run_clear(input string name);
        int n;
        n = 0;
        while (dm_if.busy === 1'b1 && n < 100) begin
            dm_if.dm_we    = 1'b1;
            dm_if.dm_wdata = 32'hFFFF_FFFF;
            dm_if.dm_addr  = (n % 2 == 1) ? 32'h0000_0041 : 32'h0000_0000;
            #1;
            chk({name, "_rdata_during_clear"}, dm_if.dm_rdata, 32'h0);
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_clear_cycles"}, n, DEPTH);
        dm_if.dm_we = 1'b0;
        chk({name, "_err_mis_after_clear"}, dm_if.err_misaligned, 1'b0);
        chk({name, "_err_rng_after_clear"}, dm_if.err_range, 1'b0);
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        dm_if.dm_we   = 1'b0;
        dm_if.dm_addr = addr;
        #1;
        chk(name, dm_if.dm_rdata, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b0;
        dm_if.dm_we    = 1'b0;
        dm_if.dm_addr  = '0;
        dm_if.dm_wdata = '0;

        vecs[0]  = '{1'b1, 32'h3C,  32'hDEAD_BEEF, 32'h0,         0, 0, 0, 32'h0};
        vecs[1]  = '{1'b0, 32'h3C,  32'h0,         32'hDEAD_BEEF, 0, 0, 0, 32'h0};
        vecs[2]  = '{1'b0, 32'h3E,  32'h0,         32'hDEAD_BEEF, 0, 0, 0, 32'h0};
        vecs[3]  = '{1'b1, 32'h00,  32'h1234_5678, 32'h0,         0, 0, 0, 32'h0};
        vecs[4]  = '{1'b1, 32'h02,  32'h1,         32'h1234_5678, 0, 0, 0, 32'h0};
        vecs[5]  = '{1'b0, 32'h00,  32'h0,         32'h1234_5678, 1, 0, 0, 32'h0};
        vecs[6]  = '{1'b1, 32'h40,  32'h55,        32'h0,         1, 0, 0, 32'h0};
        vecs[7]  = '{1'b0, 32'h40,  32'h0,         32'h0,         1, 1, 0, 32'h0};
        vecs[8]  = '{1'b1, MMIO,    32'hA,         32'h0,         1, 1, 0, 32'h0};
        vecs[9]  = '{1'b1, MMIO,    32'hB,         32'h1,         1, 1, 1, 32'hA};
        vecs[10] = '{1'b0, MMIO,    32'h0,         32'h2,         1, 1, 1, 32'hB};
        vecs[11] = '{1'b0, 32'h04,  32'h0,         32'h0,         1, 1, 0, 32'hB};
        vecs[12] = '{1'b1, 32'h20,  32'hCAFE,      32'h0,         1, 1, 0, 32'hB};
        vecs[13] = '{1'b0, 32'h20,  32'h0,         32'hCAFE,      1, 1, 0, 32'hB};
        vecs[14] = '{1'b0, 32'h3C,  32'h0,         32'hDEAD_BEEF, 1, 1, 0, 32'hB};
        vecs[15] = '{1'b0, 32'h00,  32'h0,         32'h1234_5678, 1, 1, 0, 32'hB};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", dm_if.busy, 1'b1);
        chk("rst_mmio_valid", dm_if.mmio_valid, 1'b0);
        chk("rst_mmio_data", dm_if.mmio_data, 32'h0);
        chk("rst_err_mis", dm_if.err_misaligned, 1'b0);
        chk("rst_err_rng", dm_if.err_range, 1'b0);

        // Clear after release, with ignored writes
        rst = 1'b1;
        run_clear("t1");
        read_chk("t1_word0_still_zero", 32'h0, 32'h0);
        read_chk("t1_mmio_cnt_zero", MMIO, 32'h0);

        // SERVE vectors, one per cycle; checks happen before the edge
        for (int i = 0; i < 16; i++) begin
            dm_if.dm_we    = vecs[i].we;
            dm_if.dm_addr  = vecs[i].addr;
            dm_if.dm_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_rdata", i), dm_if.dm_rdata, vecs[i].rdata);
            chk($sformatf("v%0d_err_mis", i), dm_if.err_misaligned, vecs[i].mis);
            chk($sformatf("v%0d_err_rng", i), dm_if.err_range, vecs[i].rng);
            chk($sformatf("v%0d_mmio_valid", i), dm_if.mmio_valid, vecs[i].mv);
            chk($sformatf("v%0d_mmio_data", i), dm_if.mmio_data, vecs[i].mdata);
            @(posedge clk);
            #1;
        end
        dm_if.dm_we = 1'b0;

        // Reset asserted on clear cycle 5 restarts the full clear
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_busy_mid_clear", dm_if.busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6_busy_in_reset", dm_if.busy, 1'b1);
        chk("t6_err_mis_reset", dm_if.err_misaligned, 1'b0);
        chk("t6_mmio_data_reset", dm_if.mmio_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_clear("t6");
        read_chk("t6_word15_cleared", 32'h3C, 32'h0);
        read_chk("t6_word0_cleared", 32'h00, 32'h0);
        read_chk("t6_word8_cleared", 32'h20, 32'h0);
        read_chk("t6_mmio_cnt_cleared", MMIO, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
